spm_seq_ctrl: RTL
=================

Name: spm_seq_ctrl

Overview:
- Sequencer for the serial-parallel multiplier (spm) CSA chain.
- Accepts an operand pair over a valid/ready request channel. Drives the multiplicand in parallel and the multiplier serially, LSB first, into the spm.
- Deserialises the spm serial product output into a 2*WIDTH-bit result and presents it on a valid/ready response channel.
- Sits between the requesting datapath and one spm instance. Exactly one multiplication is in flight at a time.

Parameters:
- WIDTH, 32: operand width; must match the spm instance width (>=2).
- P_DLY, 1: cycles from driving multiplier/zero bit k on spm_y to product bit k appearing on spm_p (0..3).

Ports:
- clk  input  1  single clock; all flops rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  operand pair valid.
- req_ready  output  1  controller can accept operands.
- req_a  input  WIDTH  multiplicand (unsigned).
- req_b  input  WIDTH  multiplier (unsigned).
- spm_x  output  WIDTH  parallel multiplicand to spm.
- spm_y  output  1  serial multiplier bit to spm.
- spm_clr  output  1  synchronous clear of spm CSA state; wired into the spm reset.
- spm_p  input  1  serial product bit from spm.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_p  output  2*WIDTH  product a*b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, count=0, x_reg=0, y_sh=0, p_sh=0.
  - Outputs while in reset state: req_ready=1, res_valid=0, spm_x=0, spm_y=0, spm_clr=1, busy=0.
  - rst overrides all other inputs in any state. A mid-operation reset discards the operation and produces no res_valid.
- States: IDLE, CLEAR, RUN, DONE. Encoding is free.
- IDLE:
  - req_ready=1, spm_clr=1, spm_y=0.
  - On req_valid&&req_ready: x_reg<=req_a, y_sh<=req_b, p_sh<=0, count<=0, go to CLEAR.
- CLEAR (exactly 1 cycle):
  - spm_clr=1, req_ready=0, spm_x=x_reg.
  - Flushes any residue in the CSA chain.
  - Go to RUN.
- RUN:
  - spm_clr=0, spm_x=x_reg (stable for the whole operation), spm_y=y_sh[0].
  - Every cycle: y_sh<=y_sh>>1 (zero-fill), count<=count+1.
  - Cycles 0..WIDTH-1 present b bits LSB first. Cycles WIDTH..2*WIDTH-1 present zeros to flush carries.
  - When count>=P_DLY: p_sh<={spm_p, p_sh[2*WIDTH-1:1]}. After capture, p_sh[0]=product bit 0.
  - Capture count is exactly 2*WIDTH. RUN lasts 2*WIDTH+P_DLY cycles (count 0..2*WIDTH+P_DLY-1).
  - On the final cycle, go to DONE.
  - count width is clog2(2*WIDTH+P_DLY+1).
- DONE:
  - res_valid=1, res_p=p_sh, held stable while res_ready=0. req_ready=0, spm_clr=1.
  - On res_valid&&res_ready: go to IDLE.
  - No same-cycle new accept: req_ready rises the cycle after the handshake.
- Latency: req handshake edge to first res_valid cycle = 1 (CLEAR) + 2*WIDTH+P_DLY (RUN) cycles. WIDTH=8, P_DLY=1: 18 cycles.
- Throughput: one result per 2*WIDTH+P_DLY+3 cycles minimum (IDLE, CLEAR, RUN, DONE), assuming immediate res_ready.
- req_valid held in a non-IDLE state is ignored (req_ready=0); req_a and req_b are not sampled.
- Product is exact unsigned; no overflow is possible in 2*WIDTH bits. Edge results: 0*x=0, max*max=2^(2W)-2^(W+1)+1.
- res_ready asserted outside DONE has no effect.

Test Plan:
1. WIDTH=8, P_DLY=1, behavioural spm model; req_a=3, req_b=5 -> res_valid exactly 18 cycles after accept; res_p=16'd15. spm_y sequence 1,0,1,0,0,0,0,0 then 8 zeros.
2. req_a=8'hFF, req_b=8'hFF -> res_p=16'hFE01. req_a=0, req_b=8'hA5 -> res_p=0.
3. Back-to-back requests with req_valid held high; second pair (7,9) offered during RUN -> not accepted until IDLE; results 15 then 63, in order; req_ready low during CLEAR/RUN/DONE.
4. res_ready held low 5 cycles in DONE -> res_valid and res_p=15 stable; no new accept until the cycle after the handshake.
5. rst pulsed at RUN count=6 -> next cycle IDLE, req_ready=1, spm_clr=1, res_valid never asserted. Next request (12,12) -> res_p=144.
6. Sweep P_DLY=0 and P_DLY=3 with 200 random pairs vs golden a*b -> all match; latencies 17 and 20 cycles.

Source files
------------

// File: rtl/spm_seq_ctrl.sv
// Sequencer for a serial-parallel multiplier: feeds the multiplier LSB first,
// flushes the CSA carries with zeros and reassembles the 2*WIDTH-bit product.
module spm_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int P_DLY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  output logic               spm_clr,
  input  logic               spm_p,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_p,
  output logic               busy
);

  localparam int PW      = 2 * WIDTH;
  localparam int RUN_LEN = PW + P_DLY;
  localparam int CW      = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_sh;
  logic [PW-1:0]   p_sh;
  logic            last_run;
  logic            capture;

  assign last_run = (count == CW'(RUN_LEN - 1));
  // The spm output lags spm_y by P_DLY cycles, so capture starts late and runs on past the flush.
  assign capture  = (count >= CW'(P_DLY));

  assign spm_x = x_reg;
  assign res_p = p_sh;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    spm_clr   = 1'b1;
    spm_y     = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = CLEAR;
      end
      CLEAR: state_nx = RUN;
      RUN: begin
        spm_clr = 1'b0;
        spm_y   = y_sh[0];
        if (last_run) state_nx = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      x_reg <= '0;
      y_sh  <= '0;
      p_sh  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            x_reg <= req_a;
            y_sh  <= req_b;
            p_sh  <= '0;
            count <= '0;
          end
        end
        RUN: begin
          y_sh  <= y_sh >> 1;
          count <= count + CW'(1);
          if (capture) p_sh <= {spm_p, p_sh[PW-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
